// File: rtl/pipe_instr_chain_if.sv
// Bundle between the fetch side / stall unit and the four-stage instruction chain.
// The front end is written only when stall=0 (stall acts as an inverted ready); if_valid marks a real fetch.
interface pipe_instr_chain_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      if_instr;
  logic [31:0]      if_pc;
  logic             if_valid;
  logic             stall;
  logic             pc_en;
  logic [31:0]      if_id_I;
  logic [31:0]      id_ex_I;
  logic [31:0]      ex_mem_I;
  logic [31:0]      mem_wb_I;
  logic [31:0]      if_id_pc;
  logic [31:0]      id_ex_pc;
  logic [31:0]      ex_mem_pc;
  logic [31:0]      mem_wb_pc;
  logic             if_id_v;
  logic             id_ex_v;
  logic             ex_mem_v;
  logic             mem_wb_v;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output if_instr, if_pc, if_valid, stall,
    input  pc_en, if_id_I, id_ex_I, ex_mem_I, mem_wb_I,
    input  if_id_pc, id_ex_pc, ex_mem_pc, mem_wb_pc,
    input  if_id_v, id_ex_v, ex_mem_v, mem_wb_v,
    input  stall_cnt, retire_cnt
  );

  modport slave (
    input  if_instr, if_pc, if_valid, stall,
    output pc_en, if_id_I, id_ex_I, ex_mem_I, mem_wb_I,
    output if_id_pc, id_ex_pc, ex_mem_pc, mem_wb_pc,
    output if_id_v, id_ex_v, ex_mem_v, mem_wb_v,
    output stall_cnt, retire_cnt
  );
endinterface

// File: rtl/pipe_instr_chain.sv
// IF/ID -> ID/EX -> EX/MEM -> MEM/WB instruction/PC/valid chain with stall-driven bubble
// injection and saturating stall / retire counters.
module pipe_instr_chain #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input logic              clk,
  input logic              reset,
  pipe_instr_chain_if.slave bus
);
  logic [31:0]      r_if_id_I, r_id_ex_I, r_ex_mem_I, r_mem_wb_I;
  logic [31:0]      r_if_id_pc, r_id_ex_pc, r_ex_mem_pc, r_mem_wb_pc;
  logic             r_if_id_v, r_id_ex_v, r_ex_mem_v, r_mem_wb_v;
  logic [CNT_W-1:0] r_stall_cnt, r_retire_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_id_I   <= 32'h0;
      r_id_ex_I   <= 32'h0;
      r_ex_mem_I  <= 32'h0;
      r_mem_wb_I  <= 32'h0;
      r_if_id_pc  <= PC_RESET;
      r_id_ex_pc  <= PC_RESET;
      r_ex_mem_pc <= PC_RESET;
      r_mem_wb_pc <= PC_RESET;
      r_if_id_v   <= 1'b0;
      r_id_ex_v   <= 1'b0;
      r_ex_mem_v  <= 1'b0;
      r_mem_wb_v  <= 1'b0;
    end else begin
      // Back end always drains, even while the front end is frozen.
      r_ex_mem_I  <= r_id_ex_I;
      r_ex_mem_pc <= r_id_ex_pc;
      r_ex_mem_v  <= r_id_ex_v;
      r_mem_wb_I  <= r_ex_mem_I;
      r_mem_wb_pc <= r_ex_mem_pc;
      r_mem_wb_v  <= r_ex_mem_v;
      if (bus.stall) begin
        r_id_ex_I  <= 32'h0;
        r_id_ex_pc <= r_if_id_pc;
        r_id_ex_v  <= 1'b0;
      end else begin
        r_if_id_I  <= bus.if_instr;
        r_if_id_pc <= bus.if_pc;
        r_if_id_v  <= bus.if_valid;
        r_id_ex_I  <= r_if_id_I;
        r_id_ex_pc <= r_if_id_pc;
        r_id_ex_v  <= r_if_id_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (bus.stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (r_mem_wb_v && (r_retire_cnt != {CNT_W{1'b1}}))
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_en      = ~bus.stall;
  assign bus.if_id_I    = r_if_id_I;
  assign bus.id_ex_I    = r_id_ex_I;
  assign bus.ex_mem_I   = r_ex_mem_I;
  assign bus.mem_wb_I   = r_mem_wb_I;
  assign bus.if_id_pc   = r_if_id_pc;
  assign bus.id_ex_pc   = r_id_ex_pc;
  assign bus.ex_mem_pc  = r_ex_mem_pc;
  assign bus.mem_wb_pc  = r_mem_wb_pc;
  assign bus.if_id_v    = r_if_id_v;
  assign bus.id_ex_v    = r_id_ex_v;
  assign bus.ex_mem_v   = r_ex_mem_v;
  assign bus.mem_wb_v   = r_mem_wb_v;
  assign bus.stall_cnt  = r_stall_cnt;
  assign bus.retire_cnt = r_retire_cnt;
endmodule
